analog_iter_scheduler: RTL and testbench

- Sequences multi-iteration annealing runs on the analog RX path.
- Configures the RX write/compute timing once per run, then loads an initial spin vector from the digital side.
- Each iteration: pushes the current spin vector through the RX pop handshake, waits for analog compute-finish, and captures the analog readout as the next iteration's spin vector.
- Sits between the digital spin source/sink and the analog RX wrapper.

---
 rtl/analog_iter_sched_pkg.sv | 23 ++
 rtl/analog_iter_scheduler_rise_detect.sv | 23 ++
 rtl/analog_iter_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_analog_iter_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/analog_iter_sched_pkg.sv
// Shared types and sizing helpers for the analog annealing iteration scheduler.
package analog_iter_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        LOAD,
        PUSH,
        WAIT,
        SAMPLE,
        DONE
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

    // Counter must be able to hold the full TIMEOUT_CYCLES value.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int unsigned TIMEOUT_CNT_W = timeout_cnt_width(TIMEOUT_CYCLES_DEFAULT);

endpackage

// File: rtl/analog_iter_scheduler_rise_detect.sv
// Registered rising-edge detector: flags a 0->1 transition of d_i against
// the value held from the previous cycle.
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Track the previous-cycle level of the input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/analog_iter_scheduler.sv
// Multi-iteration annealing sequencer for the analog RX path: configures RX
// timing, loads an initial spin vector, then loops push -> compute-wait ->
// readout capture for iter_num iterations.
// Optional compute-wait watchdog: define ANALOG_ITER_SCHED_TIMEOUT_EN.
module analog_iter_scheduler
    import analog_iter_sched_pkg::*;
#(
    parameter int unsigned NUM_SPIN         = 256,
    parameter int unsigned COUNTER_BITWIDTH = 8,
    parameter int unsigned ITER_BITWIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        start_i,
    input  logic [ITER_BITWIDTH-1:0]    iter_num_i,
    input  logic [COUNTER_BITWIDTH-1:0] cycle_write_i,
    input  logic [COUNTER_BITWIDTH-1:0] cycle_compute_i,
    input  logic [NUM_SPIN-1:0]         wwl_strobe_i,
    input  logic [NUM_SPIN-1:0]         spin_mode_i,
    input  logic                        init_valid_i,
    output logic                        init_ready_o,
    input  logic [NUM_SPIN-1:0]         init_spin_i,
    output logic                        rx_configure_enable_o,
    output logic [COUNTER_BITWIDTH-1:0] cycle_per_spin_write_o,
    output logic [COUNTER_BITWIDTH-1:0] cycle_per_spin_compute_o,
    output logic [NUM_SPIN-1:0]         spin_wwl_strobe_o,
    output logic [NUM_SPIN-1:0]         spin_mode_o,
    output logic                        spin_pop_valid_o,
    input  logic                        spin_pop_ready_i,
    output logic [NUM_SPIN-1:0]         spin_pop_o,
    input  logic                        cmpt_finish_i,
    input  logic [NUM_SPIN-1:0]         readout_spin_i,
    output logic                        result_valid_o,
    output logic [NUM_SPIN-1:0]         result_spin_o,
    output logic [ITER_BITWIDTH-1:0]    iter_cnt_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        timeout_o
);

    state_e                      state_q, state_nxt;
    logic [ITER_BITWIDTH-1:0]    iter_num_q, iter_cnt_q;
    logic [NUM_SPIN-1:0]         spin_buf_q, result_q, wwl_q, mode_q;
    logic [COUNTER_BITWIDTH-1:0] cyc_write_q, cyc_compute_q;
    logic                        finish_rise, wd_expire, start_any;
    logic                        start_run, init_hs, sample_take;

    // The detector tracks the level continuously, so a level already high
    // on WAIT entry shows no edge until it drops and rises again.
    rise_detect u_finish_rise (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (cmpt_finish_i),
        .rise_o (finish_rise)
    );

    assign start_any = (state_q == IDLE) && start_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt             = state_q;
        start_run             = 1'b0;
        init_hs               = 1'b0;
        sample_take           = 1'b0;
        rx_configure_enable_o = 1'b0;
        init_ready_o          = 1'b0;
        spin_pop_valid_o      = 1'b0;
        spin_pop_o            = '0;
        result_valid_o        = 1'b0;
        done_o                = 1'b0;
        busy_o                = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (iter_num_i != '0) begin
                        start_run = 1'b1;
                        state_nxt = CONFIG;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            CONFIG: begin
                rx_configure_enable_o = 1'b1;
                state_nxt             = LOAD;
            end
            LOAD: begin
                init_ready_o = 1'b1;
                if (init_valid_i) begin
                    init_hs   = 1'b1;
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                spin_pop_valid_o = 1'b1;
                spin_pop_o       = spin_buf_q;
                if (spin_pop_ready_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Readout is captured on the edge cycle so it is already
                // on result_spin_o during the SAMPLE pulse.
                if (finish_rise) begin
                    sample_take = 1'b1;
                    state_nxt   = SAMPLE;
                end else if (wd_expire) begin
                    state_nxt = DONE;
                end
            end
            SAMPLE: begin
                result_valid_o = 1'b1;
                state_nxt      = (iter_cnt_q == iter_num_q) ? DONE : PUSH;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!en_i) begin
            state_nxt = IDLE;
        end
    end

    // Run configuration, spin buffer, result and iteration counter.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            iter_num_q    <= '0;
            iter_cnt_q    <= '0;
            spin_buf_q    <= '0;
            result_q      <= '0;
            wwl_q         <= '0;
            mode_q        <= '0;
            cyc_write_q   <= '0;
            cyc_compute_q <= '0;
        end else begin
            if (start_run) begin
                iter_num_q    <= iter_num_i;
                wwl_q         <= wwl_strobe_i;
                mode_q        <= spin_mode_i;
                cyc_write_q   <= cycle_write_i;
                cyc_compute_q <= cycle_compute_i;
            end
            if (start_any) begin
                iter_cnt_q <= '0;
            end
            if (init_hs) begin
                spin_buf_q <= init_spin_i;
            end
            if (sample_take) begin
                spin_buf_q <= readout_spin_i;
                result_q   <= readout_spin_i;
                if (iter_cnt_q != '1) begin
                    iter_cnt_q <= iter_cnt_q + ITER_BITWIDTH'(1);
                end
            end
        end
    end

`ifdef ANALOG_ITER_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = timeout_cnt_width(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] wd_cnt_q;
    logic             timeout_q;

    assign wd_expire = (wd_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT cycles; cleared on the push handshake into WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || (state_q == PUSH && spin_pop_ready_i)) begin
            wd_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            wd_cnt_q <= wd_cnt_q + TMO_W'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset or an accepted start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout_q <= 1'b0;
        end else if (en_i && start_any) begin
            timeout_q <= 1'b0;
        end else if (en_i && state_q == WAIT && !finish_rise && wd_expire) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign cycle_per_spin_write_o   = cyc_write_q;
    assign cycle_per_spin_compute_o = cyc_compute_q;
    assign spin_wwl_strobe_o        = wwl_q;
    assign spin_mode_o              = mode_q;
    assign result_spin_o            = result_q;
    assign iter_cnt_o               = iter_cnt_q;

endmodule

// File: tb/tb_analog_iter_scheduler.sv
// Self-checking bench for analog_iter_scheduler: protocol-level event model
// checked every cycle, directed scenarios plus randomized runs.
module tb_analog_iter_scheduler;

    localparam int unsigned NS  = 256;
    localparam int unsigned CW  = 8;
    localparam int unsigned IW  = 16;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1, en_i = 1'b1, start_i = 1'b0;
    logic [IW-1:0] iter_num_i = '0;
    logic [CW-1:0] cycle_write_i = '0, cycle_compute_i = '0;
    logic [NS-1:0] wwl_strobe_i = '0, spin_mode_i = '0, init_spin_i = '0, readout_spin_i = '0;
    logic          init_valid_i = 1'b0, spin_pop_ready_i = 1'b0, cmpt_finish_i = 1'b0;
    logic          init_ready_o, rx_configure_enable_o, spin_pop_valid_o;
    logic          result_valid_o, busy_o, done_o, timeout_o;
    logic [CW-1:0] cycle_per_spin_write_o, cycle_per_spin_compute_o;
    logic [NS-1:0] spin_wwl_strobe_o, spin_mode_o, spin_pop_o, result_spin_o;
    logic [IW-1:0] iter_cnt_o;

    analog_iter_scheduler #(
        .NUM_SPIN(NS), .COUNTER_BITWIDTH(CW), .ITER_BITWIDTH(IW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .start_i(start_i), .iter_num_i(iter_num_i),
        .cycle_write_i(cycle_write_i), .cycle_compute_i(cycle_compute_i),
        .wwl_strobe_i(wwl_strobe_i), .spin_mode_i(spin_mode_i),
        .init_valid_i(init_valid_i), .init_ready_o(init_ready_o), .init_spin_i(init_spin_i),
        .rx_configure_enable_o(rx_configure_enable_o),
        .cycle_per_spin_write_o(cycle_per_spin_write_o),
        .cycle_per_spin_compute_o(cycle_per_spin_compute_o),
        .spin_wwl_strobe_o(spin_wwl_strobe_o), .spin_mode_o(spin_mode_o),
        .spin_pop_valid_o(spin_pop_valid_o), .spin_pop_ready_i(spin_pop_ready_i),
        .spin_pop_o(spin_pop_o), .cmpt_finish_i(cmpt_finish_i), .readout_spin_i(readout_spin_i),
        .result_valid_o(result_valid_o), .result_spin_o(result_spin_o), .iter_cnt_o(iter_cnt_o),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] rnd_spin();
        logic [NS-1:0] r;
        for (int i = 0; i < int'(NS / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    bit            model_ok = 0;
    bit            e_busy, e_cfg, e_load, e_push, e_res, e_done, e_tmo;
    logic [IW-1:0] e_cnt = '0;
    logic [NS-1:0] e_rspin = '0, e_wwl = '0, e_mode = '0;
    logic [CW-1:0] e_cw = '0, e_cc = '0;
    logic [NS-1:0] pop_q[$];
    int unsigned   run_n, k_done, wcnt;
    bit            armed, res_more, fin_prev;
    int            seen_cfg = 0, seen_pop = 0, seen_res = 0, seen_done = 0;

    always @(negedge clk) begin
        bit            n_busy, n_cfg, n_load, n_push, n_res, n_done, n_tmo;
        logic [IW-1:0] n_cnt;
        logic [NS-1:0] n_rspin;
        if (model_ok) begin
            chk("busy", NS'(busy_o), NS'(e_busy));
            chk("rx_cfg", NS'(rx_configure_enable_o), NS'(e_cfg));
            chk("init_ready", NS'(init_ready_o), NS'(e_load));
            chk("pop_valid", NS'(spin_pop_valid_o), NS'(e_push));
            chk("result_valid", NS'(result_valid_o), NS'(e_res));
            chk("done", NS'(done_o), NS'(e_done));
            chk("timeout", NS'(timeout_o), NS'(e_tmo));
            chk("iter_cnt", NS'(iter_cnt_o), NS'(e_cnt));
            chk("result_spin", result_spin_o, e_rspin);
            chk("cyc_write", NS'(cycle_per_spin_write_o), NS'(e_cw));
            chk("cyc_compute", NS'(cycle_per_spin_compute_o), NS'(e_cc));
            chk("wwl", spin_wwl_strobe_o, e_wwl);
            chk("mode", spin_mode_o, e_mode);
            if (e_push) begin
                if (pop_q.size() == 0) chk("pop_expected", NS'(spin_pop_valid_o), '0);
                else chk("pop_data", spin_pop_o, pop_q[0]);
            end
        end
        if (rx_configure_enable_o === 1'b1) seen_cfg++;
        if (spin_pop_valid_o === 1'b1 && spin_pop_ready_i) seen_pop++;
        if (result_valid_o === 1'b1) seen_res++;
        if (done_o === 1'b1) seen_done++;

        n_busy = e_busy; n_cfg = 0; n_load = 0; n_push = 0; n_res = 0; n_done = 0;
        n_tmo = e_tmo; n_cnt = e_cnt; n_rspin = e_rspin;
        if (rst_i || !en_i) begin
            n_busy = 0; n_cnt = '0; n_rspin = '0;
            e_cw = '0; e_cc = '0; e_wwl = '0; e_mode = '0;
            pop_q.delete(); armed = 0;
            if (rst_i) n_tmo = 0;
        end else begin
            if (!e_busy && start_i) begin
                n_busy = 1; n_tmo = 0; n_cnt = '0;
                if (iter_num_i != '0) begin
                    n_cfg = 1; run_n = iter_num_i; k_done = 0;
                    e_cw = cycle_write_i; e_cc = cycle_compute_i;
                    e_wwl = wwl_strobe_i; e_mode = spin_mode_i;
                end else begin
                    n_done = 1;
                end
            end
            if (e_cfg) n_load = 1;
            if (e_load) begin
                if (init_valid_i) begin pop_q.push_back(init_spin_i); n_push = 1; end
                else n_load = 1;
            end
            if (armed) begin
                if (cmpt_finish_i && !fin_prev) begin
                    armed = 0; k_done++; n_res = 1; n_rspin = readout_spin_i;
                    if (e_cnt != '1) n_cnt = e_cnt + 16'd1;
                    res_more = (k_done < run_n);
                    if (res_more) pop_q.push_back(readout_spin_i);
                end else begin
                    wcnt++;
`ifdef ANALOG_ITER_SCHED_TIMEOUT_EN
                    if (wcnt == TMO) begin armed = 0; n_done = 1; n_tmo = 1; end
`endif
                end
            end
            if (e_push) begin
                if (spin_pop_ready_i) begin
                    armed = 1; wcnt = 0;
                    if (pop_q.size() > 0) void'(pop_q.pop_front());
                end else n_push = 1;
            end
            if (e_res) begin
                if (res_more) n_push = 1; else n_done = 1;
            end
            if (e_done) n_busy = 0;
        end
        e_busy = n_busy; e_cfg = n_cfg; e_load = n_load; e_push = n_push;
        e_res = n_res; e_done = n_done; e_tmo = n_tmo; e_cnt = n_cnt; e_rspin = n_rspin;
        fin_prev = cmpt_finish_i;
        model_ok = model_ok | rst_i;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return init_ready_o;
            1: return spin_pop_valid_o;
            default: return done_o;
        endcase
    endfunction

    task automatic wait_on(input int k, input string nm);
        int n = 0;
        while (!sig(k) && n < 40) begin tick(); n++; end
        if (!sig(k)) begin
            n_chk++; n_fail++;
            $display("FAIL wait_%s: not seen within 40 cycles", nm);
        end
    endtask

    task automatic run(input int unsigned n, input logic [CW-1:0] cw, input logic [CW-1:0] cc,
                       input logic [NS-1:0] init, input bit stale, input int hold,
                       input int abort_k, input bit fin_never);
        cycle_write_i = cw; cycle_compute_i = cc;
        wwl_strobe_i = rnd_spin(); spin_mode_i = rnd_spin();
        iter_num_i = IW'(n); start_i = 1'b1;
        tick();
        start_i = 1'b0; iter_num_i = IW'($urandom);
        cycle_write_i = CW'($urandom); wwl_strobe_i = rnd_spin();
        if (n == 0) begin wait_on(2, "done"); tick(); return; end
        wait_on(0, "init_ready");
        repeat ($urandom_range(0, 2)) tick();
        init_spin_i = init; init_valid_i = 1'b1;
        tick();
        init_valid_i = 1'b0; init_spin_i = rnd_spin();
        for (int k = 0; k < int'(n); k++) begin
            wait_on(1, "pop_valid");
            if (k == 0) chk("first_pop", spin_pop_o, init);
            repeat (hold) tick();
            spin_pop_ready_i = 1'b1;
            tick();
            spin_pop_ready_i = 1'b0;
            if (abort_k == k) begin
                repeat (2) tick();
                en_i = 1'b0;
                tick();
                en_i = 1'b1; cmpt_finish_i = 1'b0;
                chk("abort_busy", NS'(busy_o), '0);
                return;
            end
            if (fin_never) begin wait_on(2, "done"); tick(); return; end
            if (cmpt_finish_i) begin
                repeat (2) tick();
                cmpt_finish_i = 1'b0;
                repeat (4) tick();
            end else begin
                repeat ($urandom_range(0, 4)) tick();
            end
            readout_spin_i = rnd_spin(); cmpt_finish_i = 1'b1;
            tick();
            readout_spin_i = rnd_spin();
            if (!stale) cmpt_finish_i = 1'b0;
        end
        wait_on(2, "done");
        tick();
        cmpt_finish_i = 1'b0;
    endtask

    initial begin
        int c0, p0, r0, d0;
        logic [NS-1:0] a5;
        a5 = {32{8'hA5}};
        repeat (3) tick();
        chk("rst_busy", NS'(busy_o), '0);
        chk("rst_done", NS'(done_o), '0);
        chk("rst_iter_cnt", NS'(iter_cnt_o), '0);
        chk("rst_timeout", NS'(timeout_o), '0);
        chk("rst_pop_valid", NS'(spin_pop_valid_o), '0);
        chk("rst_cyc_write", NS'(cycle_per_spin_write_o), '0);
        rst_i = 1'b0;
        tick();

        // Three iterations with fixed timing and 0xA5 init vector.
        c0 = seen_cfg; p0 = seen_pop; r0 = seen_res; d0 = seen_done;
        run(3, 8'd4, 8'd8, a5, 0, 1, -1, 0);
        chk("t1_iter_cnt", NS'(iter_cnt_o), NS'(3));
        chk("t1_cyc_write", NS'(cycle_per_spin_write_o), NS'(4));
        chk("t1_cyc_compute", NS'(cycle_per_spin_compute_o), NS'(8));
        chk("t1_cfg_pulses", NS'(seen_cfg - c0), NS'(1));
        chk("t1_pops", NS'(seen_pop - p0), NS'(3));
        chk("t1_results", NS'(seen_res - r0), NS'(3));
        chk("t1_done", NS'(seen_done - d0), NS'(1));

        // RX not ready for 10 cycles: exactly one handshake.
        p0 = seen_pop;
        run(1, 8'd2, 8'd3, rnd_spin(), 0, 10, -1, 0);
        chk("hold_pops", NS'(seen_pop - p0), NS'(1));

        // Finish level left high across the push: stale level ignored.
        r0 = seen_res;
        run(3, 8'd1, 8'd1, rnd_spin(), 1, 0, -1, 0);
        chk("stale_results", NS'(seen_res - r0), NS'(3));

        // Zero iterations: straight to done, no RX activity.
        c0 = seen_cfg; p0 = seen_pop; d0 = seen_done;
        run(0, 8'd5, 8'd5, rnd_spin(), 0, 0, -1, 0);
        chk("zero_cfg", NS'(seen_cfg - c0), '0);
        chk("zero_pops", NS'(seen_pop - p0), '0);
        chk("zero_done", NS'(seen_done - d0), NS'(1));

        // Enable dropped in WAIT of iteration 2, then a clean run.
        d0 = seen_done;
        run(4, 8'd7, 8'd9, rnd_spin(), 0, 0, 1, 0);
        repeat (2) tick();
        chk("abort_done", NS'(seen_done - d0), '0);
        chk("abort_iter_cnt", NS'(iter_cnt_o), '0);
        run(2, 8'd3, 8'd6, rnd_spin(), 0, 0, -1, 0);
        chk("after_abort_cnt", NS'(iter_cnt_o), NS'(2));

        // Start coincident with enable low is ignored.
        en_i = 1'b0; start_i = 1'b1; iter_num_i = 16'd2;
        tick();
        en_i = 1'b1; start_i = 1'b0;
        tick();
        chk("en_low_start_busy", NS'(busy_o), '0);

`ifdef ANALOG_ITER_SCHED_TIMEOUT_EN
        d0 = seen_done; r0 = seen_res;
        run(2, 8'd1, 8'd1, rnd_spin(), 0, 0, -1, 1);
        chk("tmo_flag", NS'(timeout_o), NS'(1));
        chk("tmo_no_result", NS'(seen_res - r0), '0);
        chk("tmo_done", NS'(seen_done - d0), NS'(1));
        run(1, 8'd1, 8'd1, rnd_spin(), 0, 0, -1, 0);
        chk("tmo_cleared", NS'(timeout_o), '0);
`endif

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            run($urandom_range(1, 5), CW'($urandom), CW'($urandom), rnd_spin(),
                bit'($urandom_range(0, 1)), $urandom_range(0, 3), -1, 0);
        end
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
